hog_block_tx: RTL and testbench



---
 rtl/hog_pkg.sv | 25 ++
 rtl/hog_block_tx_if.sv | 44 ++++
 rtl/hog_line_buf.sv | 24 ++
 rtl/hog_block_tx.sv | 137 +++++++++++++
 tb/tb_hog_block_tx.sv | 278 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/hog_pkg.sv
// Shared constants, defaults and state type for the HOG block transmitter.
package hog_pkg;

    localparam int unsigned NBIN       = 9;
    localparam int unsigned FEA_I_DEF  = 4;
    localparam int unsigned FEA_F_DEF  = 28;
    localparam int unsigned CELL_X_DEF = 8;
    localparam int unsigned CELL_Y_DEF = 16;
    localparam int unsigned BID_W_DEF  = 13;
    localparam int unsigned BLK_N      = (CELL_X_DEF - 1) * (CELL_Y_DEF - 1);

    typedef enum logic {
        ROW0   = 1'b0,
        STREAM = 1'b1
    } state_e;

    function automatic int unsigned fea_w(input int unsigned fi, input int unsigned ff);
        return fi + ff;
    endfunction

    function automatic int unsigned blk_n(input int unsigned cx, input int unsigned cy);
        return (cx - 1) * (cy - 1);
    endfunction

endpackage

// File: rtl/hog_block_tx_if.sv
// Cell-in / block-out handshake bundle of hog_block_tx.
// With HOG_BLOCK_TX_SOF_EN defined the cell side also carries i_sof.
interface hog_block_tx_if #(
    parameter int unsigned FW    = hog_pkg::FEA_I_DEF + hog_pkg::FEA_F_DEF,
    parameter int unsigned BID_W = hog_pkg::BID_W_DEF
);
    localparam int unsigned HW = hog_pkg::NBIN * FW;

    logic [HW-1:0]    i_hist;
    logic             i_valid;
    logic             i_ready;
`ifdef HOG_BLOCK_TX_SOF_EN
    logic             i_sof;
`endif
    logic [HW-1:0]    o_fea_a;
    logic [HW-1:0]    o_fea_b;
    logic [HW-1:0]    o_fea_c;
    logic [HW-1:0]    o_fea_d;
    logic             o_valid;
    logic             o_ready;
    logic [BID_W-1:0] o_bid;
    logic             o_last;

`ifdef HOG_BLOCK_TX_SOF_EN
    modport slave (
        input  i_hist, i_valid, i_sof, o_ready,
        output i_ready, o_fea_a, o_fea_b, o_fea_c, o_fea_d, o_valid, o_bid, o_last
    );
    modport master (
        output i_hist, i_valid, i_sof, o_ready,
        input  i_ready, o_fea_a, o_fea_b, o_fea_c, o_fea_d, o_valid, o_bid, o_last
    );
`else
    modport slave (
        input  i_hist, i_valid, o_ready,
        output i_ready, o_fea_a, o_fea_b, o_fea_c, o_fea_d, o_valid, o_bid, o_last
    );
    modport master (
        output i_hist, i_valid, o_ready,
        input  i_ready, o_fea_a, o_fea_b, o_fea_c, o_fea_d, o_valid, o_bid, o_last
    );
`endif

endinterface

// File: rtl/hog_line_buf.sv
// One-row cell buffer: synchronous write, combinational read of the old
// contents at the same address (read-before-write), no reset.
module hog_line_buf #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned WIDTH = 288
) (
    input  logic                                    clk,
    input  logic                                    we_i,
    input  logic [((DEPTH > 1) ? $clog2(DEPTH) : 1)-1:0] addr_i,
    input  logic [WIDTH-1:0]                        wdata_i,
    output logic [WIDTH-1:0]                        rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/hog_block_tx.sv
// Turns a raster stream of 9-bin cell histograms into overlapping 2x2 cell
// blocks for the SVM. Optional HOG_BLOCK_TX_SOF_EN adds an i_sof frame restart.
module hog_block_tx
    import hog_pkg::*;
#(
    parameter int unsigned FEA_I  = FEA_I_DEF,
    parameter int unsigned FEA_F  = FEA_F_DEF,
    parameter int unsigned CELL_X = CELL_X_DEF,
    parameter int unsigned CELL_Y = CELL_Y_DEF,
    parameter int unsigned BID_W  = BID_W_DEF
) (
    input  logic           clk,
    input  logic           rst,
    hog_block_tx_if.slave  bus
);

    localparam int unsigned FW   = fea_w(FEA_I, FEA_F);
    localparam int unsigned HW   = NBIN * FW;
    localparam int unsigned CXW  = (CELL_X > 1) ? $clog2(CELL_X) : 1;
    localparam int unsigned CYW  = (CELL_Y > 1) ? $clog2(CELL_Y) : 1;
    localparam int unsigned NBLK = blk_n(CELL_X, CELL_Y);

    state_e           state_q;
    logic [CXW-1:0]   cx_q;
    logic [CYW-1:0]   cy_q;
    logic [BID_W-1:0] bid_q;
    logic [HW-1:0]    up_prev_q;
    logic [HW-1:0]    cur_prev_q;
    logic             o_valid_q;
    logic             o_last_q;
    logic [BID_W-1:0] o_bid_q;
    logic [HW-1:0]    fea_a_q, fea_b_q, fea_c_q, fea_d_q;

    logic [HW-1:0]    lb_rdata;
    logic             sof;
    logic [CXW-1:0]   pos_x;
    logic [CYW-1:0]   pos_y;
    state_e           pos_st;
    logic             acc;
    logic             emit;
    logic             row_end;
    logic             frame_end;
    logic             blk_last;

    // Effective position of the incoming cell; a start-of-frame pulse forces (0,0).
    always_comb begin
        sof = 1'b0;
`ifdef HOG_BLOCK_TX_SOF_EN
        sof = bus.i_sof;
`endif
        pos_x  = sof ? '0 : cx_q;
        pos_y  = sof ? '0 : cy_q;
        pos_st = sof ? ROW0 : state_q;
    end

    assign bus.i_ready = !o_valid_q || bus.o_ready;
    assign acc         = bus.i_valid && bus.i_ready;
    assign emit        = acc && (pos_st == STREAM) && (pos_x != '0);
    assign row_end     = (pos_x == CXW'(CELL_X - 1));
    assign frame_end   = row_end && (pos_y == CYW'(CELL_Y - 1));
    assign blk_last    = (bid_q == BID_W'(NBLK - 1));

    hog_line_buf #(
        .DEPTH (CELL_X),
        .WIDTH (HW)
    ) u_line_buf (
        .clk     (clk),
        .we_i    (acc),
        .addr_i  (pos_x),
        .wdata_i (bus.i_hist),
        .rdata_o (lb_rdata)
    );

    // Left-neighbour cells of the current and previous row, valid at cx+1.
    always_ff @(posedge clk) begin
        if (acc) begin
            up_prev_q  <= lb_rdata;
            cur_prev_q <= bus.i_hist;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ROW0;
            cx_q      <= '0;
            cy_q      <= '0;
            bid_q     <= '0;
            o_valid_q <= 1'b0;
            o_last_q  <= 1'b0;
            o_bid_q   <= '0;
            fea_a_q   <= '0;
            fea_b_q   <= '0;
            fea_c_q   <= '0;
            fea_d_q   <= '0;
        end else if (acc) begin
            cx_q <= row_end ? '0 : pos_x + CXW'(1);
            if (row_end) begin
                cy_q <= frame_end ? '0 : pos_y + CYW'(1);
            end else begin
                cy_q <= pos_y;
            end
            case (pos_st)
                ROW0:    state_q <= row_end ? STREAM : ROW0;
                STREAM:  state_q <= frame_end ? ROW0 : STREAM;
                default: state_q <= ROW0;
            endcase
            if (emit) begin
                o_valid_q <= 1'b1;
                o_last_q  <= blk_last;
                o_bid_q   <= bid_q;
                fea_a_q   <= up_prev_q;
                fea_b_q   <= lb_rdata;
                fea_c_q   <= cur_prev_q;
                fea_d_q   <= bus.i_hist;
                bid_q     <= blk_last ? '0 : bid_q + BID_W'(1);
            end else begin
                o_valid_q <= 1'b0;
                o_last_q  <= 1'b0;
                if (sof) begin
                    bid_q <= '0;
                end
            end
        end else if (bus.o_ready) begin
            o_valid_q <= 1'b0;
            o_last_q  <= 1'b0;
        end
    end

    assign bus.o_valid = o_valid_q;
    assign bus.o_last  = o_last_q;
    assign bus.o_bid   = o_bid_q;
    assign bus.o_fea_a = fea_a_q;
    assign bus.o_fea_b = fea_b_q;
    assign bus.o_fea_c = fea_c_q;
    assign bus.o_fea_d = fea_d_q;

endmodule

// File: tb/tb_hog_block_tx.sv
// Scoreboard bench for hog_block_tx: a frame-image model predicts every block,
// a monitor pops and compares whenever the DUT presents one.
module tb_hog_block_tx;
    import hog_pkg::*;

    localparam int FW  = int'(fea_w(FEA_I_DEF, FEA_F_DEF));
    localparam int HW  = int'(NBIN) * FW;
    localparam int CX  = int'(CELL_X_DEF);
    localparam int CY  = int'(CELL_Y_DEF);
    localparam int BW  = int'(BID_W_DEF);
    localparam int NBK = int'(BLK_N);

    typedef struct {
        logic [HW-1:0] a, b, c, d;
        int            bid;
        logic          last;
        int            cyc;
    } blk_t;

    logic clk = 1'b0;
    logic rst;

    hog_block_tx_if #(.FW(FW), .BID_W(BW)) bus ();

    hog_block_tx #(
        .FEA_I  (FEA_I_DEF),
        .FEA_F  (FEA_F_DEF),
        .CELL_X (CELL_X_DEF),
        .CELL_Y (CELL_Y_DEF),
        .BID_W  (BID_W_DEF)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int            checks   = 0;
    int            failures = 0;
    int            cyc      = 0;
    int            stall_pct = 0;
    int            gap_pct   = 0;
    bit            mon_en    = 1'b0;
    blk_t          exp_q[$];
    blk_t          cur;
    bit            have_cur  = 1'b0;
    int            seen      = 0;
    logic [HW-1:0] img [CY][CX];
    int            mx = 0;
    int            my = 0;

    always @(posedge clk) cyc++;

    task automatic chk(input string nm, input logic [HW-1:0] act, input logic [HW-1:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (cyc %0d)", nm, act, req, cyc);
        end
    endtask

    function automatic logic [HW-1:0] pat(input int tag, input int x, input int y);
        logic [HW-1:0] r;
        for (int k = 0; k < int'(NBIN); k++)
            r[k*FW +: FW] = {8'(tag), 8'(y), 8'(x), 8'(k)};
        return r;
    endfunction

    function automatic logic [HW-1:0] rnd_cell();
        logic [HW-1:0] r;
        for (int k = 0; k < int'(NBIN); k++) r[k*FW +: FW] = FW'($urandom());
        return r;
    endfunction

    // Reference: keep the whole frame image, a block exists at every (x>=1,y>=1).
    task automatic model_accept(input logic [HW-1:0] h, input bit sof);
        blk_t b;
        if (sof) begin
            mx = 0;
            my = 0;
        end
        img[my][mx] = h;
        if (mx >= 1 && my >= 1) begin
            b.a    = img[my-1][mx-1];
            b.b    = img[my-1][mx];
            b.c    = img[my][mx-1];
            b.d    = h;
            b.bid  = (my - 1) * (CX - 1) + (mx - 1);
            b.last = (b.bid == NBK - 1);
            b.cyc  = cyc + 1;
            exp_q.push_back(b);
        end
        mx++;
        if (mx == CX) begin
            mx = 0;
            my++;
            if (my == CY) my = 0;
        end
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic send_cell(input logic [HW-1:0] h, input bit sof);
        int guard = 0;
        while (gap_pct != 0 && int'($urandom_range(99)) < gap_pct) begin
            bus.i_valid = 1'b0;
            @(negedge clk);
        end
        bus.i_valid = 1'b1;
        bus.i_hist  = h;
`ifdef HOG_BLOCK_TX_SOF_EN
        bus.i_sof   = sof;
`endif
        forever begin
            #3;
            if (bus.i_ready === 1'b1) begin
                model_accept(h, sof);
                @(negedge clk);
                break;
            end
            guard++;
            if (guard > 1000) begin
                $display("FAIL i_ready_timeout actual=0 required=1");
                $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
                $fatal(1, "stuck");
            end
            @(negedge clk);
        end
`ifdef HOG_BLOCK_TX_SOF_EN
        bus.i_sof = 1'b0;
`endif
    endtask

    task automatic send_frame(input bit rnd, input int tag, input bit sof_first);
        for (int y = 0; y < CY; y++)
            for (int x = 0; x < CX; x++)
                send_cell(rnd ? rnd_cell() : pat(tag, x, y), sof_first && x == 0 && y == 0);
    endtask

    task automatic drain(input string nm);
        int n = 0;
        bus.i_valid = 1'b0;
        while ((exp_q.size() != 0 || have_cur) && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk({nm, "_drain_pending"}, HW'(exp_q.size() + int'(have_cur)), '0);
    endtask

    // Monitor: random back-pressure, then compare whatever the DUT presents.
    always @(negedge clk) begin
        bus.o_ready = (int'($urandom_range(99)) < stall_pct) ? 1'b0 : 1'b1;
        #3;
        if (!rst && mon_en) begin
            chk("i_ready_rule", HW'(bus.i_ready), HW'(!bus.o_valid || bus.o_ready));
            if (bus.o_valid === 1'b1) begin
                if (!have_cur) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_block_bid", HW'(bus.o_bid), '1);
                    end else begin
                        cur      = exp_q.pop_front();
                        have_cur = 1'b1;
                        seen++;
                        chk("latency_cycle", HW'(cyc), HW'(cur.cyc));
                    end
                end
                if (have_cur) begin
                    chk("fea_a", bus.o_fea_a, cur.a);
                    chk("fea_b", bus.o_fea_b, cur.b);
                    chk("fea_c", bus.o_fea_c, cur.c);
                    chk("fea_d", bus.o_fea_d, cur.d);
                    chk("bid",   HW'(bus.o_bid), HW'(cur.bid));
                    chk("last",  HW'(bus.o_last), HW'(cur.last));
                end
                if (bus.o_ready) have_cur = 1'b0;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        rst         = 1'b1;
        bus.i_valid = 1'b0;
        bus.i_hist  = '0;
        bus.o_ready = 1'b1;
`ifdef HOG_BLOCK_TX_SOF_EN
        bus.i_sof   = 1'b0;
`endif
        repeat (3) @(negedge clk);
        #3;
        chk("rst_o_valid", HW'(bus.o_valid), '0);
        chk("rst_o_last",  HW'(bus.o_last), '0);
        chk("rst_o_bid",   HW'(bus.o_bid), '0);
        chk("rst_fea_a",   bus.o_fea_a, '0);
        chk("rst_fea_b",   bus.o_fea_b, '0);
        chk("rst_fea_c",   bus.o_fea_c, '0);
        chk("rst_fea_d",   bus.o_fea_d, '0);
        chk("rst_i_ready", HW'(bus.i_ready), HW'(1));
        @(negedge clk);
        rst    = 1'b0;
        mon_en = 1'b1;
        @(negedge clk);

        // Pattern frame, no back-pressure.
        send_frame(1'b0, 1, 1'b0);
        drain("frame1");
        chk("frame1_blocks", HW'(seen), HW'(NBK));

        // Two back-to-back frames with i_valid held high.
        base = seen;
        send_frame(1'b0, 2, 1'b0);
        send_frame(1'b0, 3, 1'b0);
        drain("b2b");
        chk("b2b_blocks", HW'(seen - base), HW'(2 * NBK));

        // Random data under 50% output stalls.
        stall_pct = 50;
        send_frame(1'b1, 0, 1'b0);
        drain("stall");

        // Random input gaps, then gaps plus stalls.
        stall_pct = 0;
        gap_pct   = 30;
        send_frame(1'b1, 0, 1'b0);
        drain("gaps");
        stall_pct = 40;
        send_frame(1'b0, 4, 1'b0);
        drain("gaps_stall");

        // Asynchronous reset in the middle of row 5.
        stall_pct = 0;
        gap_pct   = 0;
        for (int i = 0; i < 5 * CX + 4; i++)
            send_cell(pat(5, i % CX, i / CX), 1'b0);
        #1;
        chk("pre_rst_o_valid", HW'(bus.o_valid), HW'(1));
        bus.i_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk("async_rst_o_valid", HW'(bus.o_valid), '0);
        chk("async_rst_o_bid",   HW'(bus.o_bid), '0);
        mon_en   = 1'b0;
        exp_q.delete();
        have_cur = 1'b0;
        mx = 0;
        my = 0;
        @(negedge clk);
        @(negedge clk);
        rst    = 1'b0;
        mon_en = 1'b1;
        base   = seen;
        send_frame(1'b1, 0, 1'b0);
        drain("post_rst");
        chk("post_rst_blocks", HW'(seen - base), HW'(NBK));

`ifdef HOG_BLOCK_TX_SOF_EN
        // Start-of-frame pulse arriving at cell (3,7) of a partial frame.
        stall_pct = 50;
        for (int i = 0; i < 7 * CX + 3; i++)
            send_cell(pat(9, i % CX, i / CX), 1'b0);
        base = seen + exp_q.size() + int'(have_cur);
        send_frame(1'b0, 10, 1'b1);
        drain("sof");
        chk("sof_blocks", HW'(seen - base), HW'(NBK));
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
